// File: rtl/sa_wormhole_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sa_wormhole_ctrl_pkg
// Brief    : Router-wide parameters and switch-allocation types.
// Revision : 1.0 - initial release
// ============================================================================
package sa_wormhole_ctrl_pkg;

    localparam int PORT_NUM  = 5;
    localparam int PORT_SIZE = $clog2(PORT_NUM);
    localparam int VC_IDX_W  = 2;

    typedef logic [PORT_SIZE-1:0] port_t;

    typedef enum logic [1:0] {
        VC_IDLE   = 2'd0,
        VC_WAIT   = 2'd1,
        VC_ACTIVE = 2'd2
    } sa_vc_state_t;

    typedef struct packed {
        logic                locked;
        port_t               owner;
        logic [VC_IDX_W-1:0] owner_vc;
    } sa_lock_t;

endpackage
`default_nettype wire

// File: rtl/sa_wormhole_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sa_wormhole_ctrl_if
// Brief    : Buffer / allocator / crossbar signals of the switch-allocation stage.
// Revision : 1.0 - initial release
// ============================================================================
interface sa_wormhole_ctrl_if #(
    parameter int VC_NUM = 2
);
    import sa_wormhole_ctrl_pkg::*;

    logic  [PORT_NUM-1:0][VC_NUM-1:0] flit_valid;
    logic  [PORT_NUM-1:0][VC_NUM-1:0] flit_head;
    logic  [PORT_NUM-1:0][VC_NUM-1:0] flit_tail;
    port_t [PORT_NUM-1:0][VC_NUM-1:0] flit_route;
    logic  [PORT_NUM-1:0][VC_NUM-1:0] sa_request;
    port_t [PORT_NUM-1:0][VC_NUM-1:0] sa_target;
    logic  [PORT_NUM-1:0][VC_NUM-1:0] sa_grant;
    logic  [PORT_NUM-1:0][VC_NUM-1:0] flit_pop;
    logic  [PORT_NUM-1:0]             xbar_valid;
    port_t [PORT_NUM-1:0]             xbar_sel;

    modport master (
        input  flit_valid, flit_head, flit_tail, flit_route, sa_grant,
        output sa_request, sa_target, flit_pop, xbar_valid, xbar_sel
    );

    modport slave (
        output flit_valid, flit_head, flit_tail, flit_route, sa_grant,
        input  sa_request, sa_target, flit_pop, xbar_valid, xbar_sel
    );

endinterface
`default_nettype wire

// File: rtl/sa_wormhole_ctrl_credit_counter.sv
`default_nettype none
// ============================================================================
// Module   : sa_credit_counter
// Brief    : Downstream credit counter for one output port with sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module sa_credit_counter #(
    parameter int CREDIT_DEPTH = 4
) (
    input  wire logic                              clk,
    input  wire logic                              RSTn,
    input  wire logic                              i_inc,
    input  wire logic                              i_dec,
    output logic [$clog2(CREDIT_DEPTH+1)-1:0]      o_count,
    output logic                                   o_err
);
    localparam int              CNT_W  = $clog2(CREDIT_DEPTH+1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CREDIT_DEPTH);

    logic [CNT_W-1:0] r_count;
    logic             r_err;

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            r_count <= C_FULL;
            r_err   <= 1'b0;
        end else begin
            // A full counter means nothing is outstanding downstream, so any return is bogus.
            if (i_inc && (r_count == C_FULL)) begin
                r_err <= 1'b1;
            end
            if (i_inc && !i_dec) begin
                if (r_count != C_FULL) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (i_dec && !i_inc) begin
                if (r_count != '0) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    assign o_count = r_count;
    assign o_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/sa_wormhole_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sa_wormhole_ctrl
// Brief    : Wormhole switch-allocation controller: VC FSMs, output locks, credits.
//            Optional SA_WORMHOLE_CTRL_STALL_CNT_EN adds per-output stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module sa_wormhole_ctrl
    import sa_wormhole_ctrl_pkg::*;
#(
    parameter int VC_NUM       = 2,
    parameter int CREDIT_DEPTH = 4
) (
    input  wire logic                  clk,
    input  wire logic                  RSTn,
    sa_wormhole_ctrl_if.master         bus,
    input  wire logic [PORT_NUM-1:0]   i_credit_ret,
    output logic                       o_credit_err
`ifdef SA_WORMHOLE_CTRL_STALL_CNT_EN
    ,
    output logic [PORT_NUM-1:0][15:0]  o_stall_cnt
`endif
);
    localparam int CNT_W = $clog2(CREDIT_DEPTH+1);

    sa_vc_state_t r_state [PORT_NUM][VC_NUM];
    port_t        r_out   [PORT_NUM][VC_NUM];
    sa_lock_t     r_lock  [PORT_NUM];
    logic  [PORT_NUM-1:0] r_xbar_valid;
    port_t [PORT_NUM-1:0] r_xbar_sel;

    logic  [CNT_W-1:0]                w_credit [PORT_NUM];
    logic  [PORT_NUM-1:0]             w_credit_err;
    logic  [PORT_NUM-1:0][VC_NUM-1:0] w_free;
    logic  [PORT_NUM-1:0][VC_NUM-1:0] w_owner;
    logic  [PORT_NUM-1:0][VC_NUM-1:0] w_cred;
    logic  [PORT_NUM-1:0][VC_NUM-1:0] w_request;
    logic  [PORT_NUM-1:0][VC_NUM-1:0] w_pop;
    port_t [PORT_NUM-1:0][VC_NUM-1:0] w_target;
    logic  [PORT_NUM-1:0]             w_dec;
    port_t [PORT_NUM-1:0]             w_src;

    // Per-VC view of the lock and credit state of the output it is routed to.
    always_comb begin
        w_free  = '0;
        w_owner = '0;
        w_cred  = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                for (int o = 0; o < PORT_NUM; o++) begin
                    if (r_out[p][v] == port_t'(o)) begin
                        w_free[p][v]  = !r_lock[o].locked;
                        w_owner[p][v] = r_lock[o].locked &&
                                        (r_lock[o].owner == port_t'(p)) &&
                                        (r_lock[o].owner_vc == VC_IDX_W'(v));
                        w_cred[p][v]  = (w_credit[o] != '0);
                    end
                end
            end
        end
    end

    always_comb begin
        w_request = '0;
        w_target  = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                case (r_state[p][v])
                    VC_WAIT: begin
                        w_target[p][v]  = r_out[p][v];
                        w_request[p][v] = w_free[p][v] && w_cred[p][v];
                    end
                    VC_ACTIVE: begin
                        w_target[p][v]  = r_out[p][v];
                        w_request[p][v] = bus.flit_valid[p][v] && w_owner[p][v] && w_cred[p][v];
                    end
                    default: begin
                        w_target[p][v]  = bus.flit_route[p][v];
                    end
                endcase
            end
        end
        if (!RSTn) begin
            w_request = '0;
        end
    end

    assign w_pop = bus.sa_grant & w_request;

    always_comb begin
        w_dec = '0;
        w_src = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    if (w_pop[p][v] && (r_out[p][v] == port_t'(o))) begin
                        w_dec[o] = 1'b1;
                        w_src[o] = port_t'(p);
                    end
                end
            end
        end
    end

    generate
        for (genvar o = 0; o < PORT_NUM; o++) begin : g_credit
            sa_credit_counter #(
                .CREDIT_DEPTH (CREDIT_DEPTH)
            ) u_credit (
                .clk     (clk),
                .RSTn    (RSTn),
                .i_inc   (i_credit_ret[o]),
                .i_dec   (w_dec[o]),
                .o_count (w_credit[o]),
                .o_err   (w_credit_err[o])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    r_state[p][v] <= VC_IDLE;
                    r_out[p][v]   <= '0;
                end
            end
            for (int o = 0; o < PORT_NUM; o++) begin
                r_lock[o] <= '0;
            end
            r_xbar_valid <= '0;
            r_xbar_sel   <= '0;
        end else begin
            r_xbar_valid <= w_dec;
            for (int o = 0; o < PORT_NUM; o++) begin
                if (w_dec[o]) begin
                    r_xbar_sel[o] <= w_src[o];
                end
            end
            for (int p = 0; p < PORT_NUM; p++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    case (r_state[p][v])
                        VC_IDLE: begin
                            if (bus.flit_valid[p][v] && bus.flit_head[p][v]) begin
                                r_state[p][v] <= VC_WAIT;
                                r_out[p][v]   <= bus.flit_route[p][v];
                            end
                        end
                        VC_WAIT: begin
                            if (w_pop[p][v]) begin
                                if (bus.flit_tail[p][v]) begin
                                    r_state[p][v] <= VC_IDLE;
                                end else begin
                                    r_state[p][v] <= VC_ACTIVE;
                                    for (int o = 0; o < PORT_NUM; o++) begin
                                        if (r_out[p][v] == port_t'(o)) begin
                                            r_lock[o] <= '{locked: 1'b1, owner: port_t'(p),
                                                           owner_vc: VC_IDX_W'(v)};
                                        end
                                    end
                                end
                            end
                        end
                        VC_ACTIVE: begin
                            if (w_pop[p][v] && bus.flit_tail[p][v]) begin
                                r_state[p][v] <= VC_IDLE;
                                for (int o = 0; o < PORT_NUM; o++) begin
                                    if (r_out[p][v] == port_t'(o)) begin
                                        r_lock[o].locked <= 1'b0;
                                    end
                                end
                            end
                        end
                        default: r_state[p][v] <= VC_IDLE;
                    endcase
                end
            end
        end
    end

`ifdef SA_WORMHOLE_CTRL_STALL_CNT_EN
    logic [PORT_NUM-1:0]       w_waiting;
    logic [PORT_NUM-1:0][15:0] r_stall_cnt;

    always_comb begin
        w_waiting = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    if ((r_state[p][v] == VC_WAIT) && (r_out[p][v] == port_t'(o))) begin
                        w_waiting[o] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            r_stall_cnt <= '0;
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if ((r_lock[o].locked || w_waiting[o]) && (w_credit[o] == '0) &&
                    (r_stall_cnt[o] != 16'hFFFF)) begin
                    r_stall_cnt[o] <= r_stall_cnt[o] + 16'd1;
                end
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

    assign bus.sa_request = w_request;
    assign bus.sa_target  = w_target;
    assign bus.flit_pop   = w_pop;
    assign bus.xbar_valid = r_xbar_valid;
    assign bus.xbar_sel   = r_xbar_sel;
    assign o_credit_err   = |w_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_sa_wormhole_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_wormhole_ctrl
// Brief    : Directed self-checking bench for sa_wormhole_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sa_wormhole_ctrl;
    import sa_wormhole_ctrl_pkg::*;

    localparam int VC_NUM       = 2;
    localparam int CREDIT_DEPTH = 4;

    logic                             clk = 1'b0;
    logic                             RSTn;
    logic [PORT_NUM-1:0]              credit_ret;
    logic                             credit_err;
    logic [PORT_NUM-1:0][VC_NUM-1:0]  grant_mask;
`ifdef SA_WORMHOLE_CTRL_STALL_CNT_EN
    logic [PORT_NUM-1:0][15:0]        stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    sa_wormhole_ctrl_if #(.VC_NUM(VC_NUM)) bus ();

    // Allocator model: grants every request (no conflicts in these scenarios).
    assign bus.sa_grant = bus.sa_request & grant_mask;

    always #5 clk = ~clk;

    sa_wormhole_ctrl #(
        .VC_NUM       (VC_NUM),
        .CREDIT_DEPTH (CREDIT_DEPTH)
    ) dut (
        .clk          (clk),
        .RSTn         (RSTn),
        .bus          (bus),
        .i_credit_ret (credit_ret),
        .o_credit_err (credit_err)
`ifdef SA_WORMHOLE_CTRL_STALL_CNT_EN
        ,
        .o_stall_cnt  (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic flit(input int p, input int v, input logic val, input logic hd,
                        input logic tl, input int rt);
        bus.flit_valid[p][v] = val;
        bus.flit_head[p][v]  = hd;
        bus.flit_tail[p][v]  = tl;
        bus.flit_route[p][v] = port_t'(rt);
    endtask

    initial begin
        RSTn           = 1'b0;
        credit_ret     = '0;
        grant_mask     = '1;
        bus.flit_valid = '0;
        bus.flit_head  = '0;
        bus.flit_tail  = '0;
        bus.flit_route = '0;

        // ---------------- reset state ----------------
        cyc();
        cyc();
        flit(3, 1, 1'b1, 1'b1, 1'b1, 0);
        @(negedge clk);
        chk("rst_request", 32'(bus.sa_request), 0);
        chk("rst_pop", 32'(bus.flit_pop), 0);
        chk("rst_xbar_valid", 32'(bus.xbar_valid), 0);
        chk("rst_credit_err", 32'(credit_err), 0);
        for (int o = 0; o < PORT_NUM; o++) begin
            chk($sformatf("rst_credit%0d", o), 32'(dut.w_credit[o]), CREDIT_DEPTH);
        end
        cyc();
        RSTn = 1'b1;
        flit(3, 1, 1'b0, 1'b0, 1'b0, 0);

        // ---------------- single-flit packet in0/vc0 -> out2 ----------------
        cyc();
        flit(0, 0, 1'b1, 1'b1, 1'b1, 2);
        @(negedge clk);
        chk("sf_idle_req", 32'(bus.sa_request[0][0]), 0);
        cyc();
        @(negedge clk);
        chk("sf_req", 32'(bus.sa_request[0][0]), 1);
        chk("sf_pop", 32'(bus.flit_pop[0][0]), 1);
        chk("sf_target", 32'(bus.sa_target[0][0]), 2);
        cyc();
        flit(0, 0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("sf_xbar_valid", 32'(bus.xbar_valid), 32'h4);
        chk("sf_xbar_sel2", 32'(bus.xbar_sel[2]), 0);
        chk("sf_credit2", 32'(dut.w_credit[2]), 3);
        chk("sf_state_idle", 32'(dut.r_state[0][0]), 32'(VC_IDLE));
        cyc();
        credit_ret[2] = 1'b1;
        @(negedge clk);
        chk("sf_xbar_pulse", 32'(bus.xbar_valid), 0);
        cyc();
        credit_ret[2] = 1'b0;
        @(negedge clk);
        chk("sf_credit2_back", 32'(dut.w_credit[2]), 4);

        // ---------------- 5-flit packet in1/vc1 -> out3, credit starved ----------------
        cyc();
        flit(1, 1, 1'b1, 1'b1, 1'b0, 3);
        @(negedge clk);
        chk("wp_head_idle_req", 32'(bus.sa_request[1][1]), 0);
        cyc();
        @(negedge clk);
        chk("wp_head_pop", 32'(bus.flit_pop[1][1]), 1);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            flit(1, 1, 1'b1, 1'b0, 1'b0, 3);
            @(negedge clk);
            chk($sformatf("wp_body%0d_pop", k), 32'(bus.flit_pop[1][1]), 1);
        end
        cyc();
        flit(1, 1, 1'b1, 1'b0, 1'b1, 3);
        @(negedge clk);
        chk("wp_tail_starved", 32'(bus.sa_request[1][1]), 0);
        chk("wp_credit3_zero", 32'(dut.w_credit[3]), 0);
        chk("wp_lock3", 32'(dut.r_lock[3].locked), 1);
        chk("wp_lock3_owner", 32'(dut.r_lock[3].owner), 1);
        cyc();
        credit_ret[3] = 1'b1;
        @(negedge clk);
        chk("wp_no_bypass", 32'(bus.sa_request[1][1]), 0);
        cyc();
        credit_ret[3] = 1'b0;
        @(negedge clk);
        chk("wp_tail_req", 32'(bus.sa_request[1][1]), 1);
        chk("wp_tail_pop", 32'(bus.flit_pop[1][1]), 1);
        cyc();
        flit(1, 1, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("wp_lock3_released", 32'(dut.r_lock[3].locked), 0);
        chk("wp_xbar_valid3", 32'(bus.xbar_valid[3]), 1);
        chk("wp_xbar_sel3", 32'(bus.xbar_sel[3]), 1);
        chk("wp_credit3_after", 32'(dut.w_credit[3]), 0);
        cyc();
        credit_ret[3] = 1'b1;
        cyc();
        cyc();
        cyc();
        cyc();
        credit_ret[3] = 1'b0;
        @(negedge clk);
        chk("wp_credit3_refill", 32'(dut.w_credit[3]), 4);
        chk("wp_no_err", 32'(credit_err), 0);

        // ---------------- lock contention on out2 ----------------
        cyc();
        flit(0, 0, 1'b1, 1'b1, 1'b0, 2);
        cyc();
        @(negedge clk);
        chk("lk_in0_head_pop", 32'(bus.flit_pop[0][0]), 1);
        cyc();
        flit(0, 0, 1'b0, 1'b0, 1'b0, 2);
        flit(4, 0, 1'b1, 1'b1, 1'b1, 2);
        @(negedge clk);
        chk("lk_in0_no_data", 32'(bus.sa_request[0][0]), 0);
        chk("lk_in4_idle", 32'(bus.sa_request[4][0]), 0);
        cyc();
        @(negedge clk);
        chk("lk_in4_blocked", 32'(bus.sa_request[4][0]), 0);
        chk("lk_lock2", 32'(dut.r_lock[2].locked), 1);
        cyc();
        flit(0, 0, 1'b1, 1'b0, 1'b1, 2);
        @(negedge clk);
        chk("lk_in0_tail_pop", 32'(bus.flit_pop[0][0]), 1);
        chk("lk_in4_still_blocked", 32'(bus.sa_request[4][0]), 0);
        cyc();
        flit(0, 0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("lk_in4_req", 32'(bus.sa_request[4][0]), 1);
        chk("lk_in4_pop", 32'(bus.flit_pop[4][0]), 1);
        chk("lk_xbar_sel2_in0", 32'(bus.xbar_sel[2]), 0);
        cyc();
        flit(4, 0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("lk_xbar_sel2_in4", 32'(bus.xbar_sel[2]), 4);
        chk("lk_credit2", 32'(dut.w_credit[2]), 1);

        // ---------------- simultaneous pop and credit return at count 2 ----------------
        cyc();
        credit_ret[2] = 1'b1;
        cyc();
        credit_ret[2] = 1'b0;
        flit(2, 0, 1'b1, 1'b1, 1'b1, 2);
        @(negedge clk);
        chk("sim_credit2_pre", 32'(dut.w_credit[2]), 2);
        cyc();
        credit_ret[2] = 1'b1;
        @(negedge clk);
        chk("sim_pop", 32'(bus.flit_pop[2][0]), 1);
        cyc();
        credit_ret[2] = 1'b0;
        flit(2, 0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("sim_credit2_held", 32'(dut.w_credit[2]), 2);
        chk("sim_no_err", 32'(credit_err), 0);

        // ---------------- credit overflow on out1 ----------------
        cyc();
        credit_ret[1] = 1'b1;
        cyc();
        credit_ret[1] = 1'b0;
        @(negedge clk);
        chk("ovf_credit1", 32'(dut.w_credit[1]), 4);
        chk("ovf_err", 32'(credit_err), 1);
        cyc();
        cyc();
        cyc();
        @(negedge clk);
        chk("ovf_err_sticky", 32'(credit_err), 1);

        // ---------------- reset in the middle of a packet ----------------
        cyc();
        flit(1, 0, 1'b1, 1'b1, 1'b0, 4);
        cyc();
        @(negedge clk);
        chk("mr_head_pop", 32'(bus.flit_pop[1][0]), 1);
        cyc();
        flit(1, 0, 1'b1, 1'b0, 1'b0, 4);
        RSTn = 1'b0;
        @(negedge clk);
        chk("mr_req_in_reset", 32'(bus.sa_request), 0);
        chk("mr_pop_in_reset", 32'(bus.flit_pop), 0);
        cyc();
        RSTn = 1'b1;
        @(negedge clk);
        chk("mr_req_after", 32'(bus.sa_request), 0);
        chk("mr_xbar_valid", 32'(bus.xbar_valid), 0);
        chk("mr_credit_err", 32'(credit_err), 0);
        for (int o = 0; o < PORT_NUM; o++) begin
            chk($sformatf("mr_credit%0d", o), 32'(dut.w_credit[o]), CREDIT_DEPTH);
            chk($sformatf("mr_lock%0d", o), 32'(dut.r_lock[o].locked), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
